unary_emit: RTL and testbench

UNARY_EMIT -- requirements
Module: unary_emit

---
 rtl/unary_emit.sv | 119 +++++++++++
 tb/tb_unary_emit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/unary_emit.sv
// unary_emit: turns a (count, length) request into a thermometer-coded
// one-bit stream of `length` beats. The first min(count, length) beats
// carry 1 and the rest carry 0. Valid/ready handshakes are used on both
// sides, and done pulses once after the final beat is accepted.
module unary_emit #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_cnt,
  input  logic [DW-1:0] in_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          one_bit,
  output logic          out_last,
  output logic          done
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t        state;
  logic [DW-1:0] rem;
  logic [DW-1:0] ones;

  logic [DW-1:0] sat_cnt;
  logic [DW-1:0] rem_dec;
  logic [DW-1:0] ones_dec;
  logic          accept;
  logic          beat;

  // Request saturation, handshake qualifiers and non-wrapping counter steps
  always_comb begin
    sat_cnt  = (in_cnt > in_len) ? in_len : in_cnt;
    accept   = in_valid && in_ready && (state == IDLE);
    beat     = out_valid && out_ready && (state == EMIT);
    rem_dec  = (rem  != '0) ? rem  - DW'(1) : '0;
    ones_dec = (ones != '0) ? ones - DW'(1) : '0;
  end

  // FSM with registered outputs; output registers are loaded from the
  // post-update counter values so they always match rem/ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      ones      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      one_bit   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state     <= IDLE;
        rem       <= '0;
        ones      <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        one_bit   <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            one_bit   <= 1'b0;
            out_last  <= 1'b0;
            if (accept) begin
              rem  <= in_len;
              ones <= sat_cnt;
              if (in_len == '0) begin
                done <= 1'b1;
              end else begin
                state     <= EMIT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                one_bit   <= (sat_cnt != '0);
                out_last  <= (in_len == DW'(1));
              end
            end
          end
          EMIT: begin
            in_ready <= 1'b0;
            if (beat) begin
              if (rem == DW'(1)) begin
                state     <= IDLE;
                rem       <= '0;
                ones      <= '0;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                one_bit   <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
              end else begin
                rem      <= rem_dec;
                ones     <= ones_dec;
                one_bit  <= (ones_dec != '0);
                out_last <= (rem_dec == DW'(1));
              end
            end
          end
          default: begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unary_emit.sv
// Testbench for unary_emit: directed scenarios plus randomized streams,
// checked against a queue-based model of the expected beat sequence.
module tb_unary_emit;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_cnt;
  logic [DW-1:0] in_len;
  logic          out_valid;
  logic          out_ready;
  logic          one_bit;
  logic          out_last;
  logic          done;

  int checks;
  int errors;

  unary_emit #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .one_bit   (one_bit),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int cnt, input int len);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_wait", in_ready, 1);
    in_valid = 1'b1;
    in_cnt   = DW'(cnt);
    in_len   = DW'(len);
    tick();
    in_valid = 1'b0;
    in_cnt   = $urandom_range(0, 255);
    in_len   = $urandom_range(0, 255);
  endtask

  // mode 0: out_ready always 1; 1: random; 2: fixed 1,0,0,1,1,0,1 pattern
  task automatic run_stream(input int cnt, input int len, input int mode);
    bit   q[$];
    bit   pat[7];
    int   idx, acc, exp_acc, budget, ri;
    logic rdy;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    exp_acc = 0;
    for (int i = 0; i < len; i++) begin
      q.push_back(i < cnt);
      if (i < cnt) exp_acc++;
    end
    accept(cnt, len);
    if (len == 0) begin
      check("zlen_valid", out_valid, 0);
      check("zlen_done", done, 1);
      check("zlen_ready", in_ready, 1);
      tick();
      check("zlen_done_once", done, 0);
      check("zlen_ready_hold", in_ready, 1);
      return;
    end
    check("lat1_valid", out_valid, 1);
    idx = 0;
    acc = 0;
    ri = 0;
    budget = 20 * len + 40;
    while (idx < len && budget > 0) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = pat[ri % 7];
      endcase
      ri++;
      out_ready = rdy;
      check("beat_valid", out_valid, 1);
      check("beat_bit", one_bit, q[idx]);
      check("beat_last", out_last, (idx == len - 1));
      check("beat_no_done", done, 0);
      check("beat_no_ready", in_ready, 0);
      if (rdy) acc += one_bit;
      tick();
      if (rdy) idx++;
      budget--;
    end
    out_ready = 1'b0;
    if (idx < len) check("stream_timeout", idx, len);
    check("done_pulse", done, 1);
    check("end_valid", out_valid, 0);
    check("end_ready", in_ready, 1);
    check("accum", acc, exp_acc);
    tick();
    check("done_once", done, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = '0;
    in_len    = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_bit", one_bit, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    // Directed scenarios
    run_stream(3, 5, 0);
    run_stream(9, 4, 0);
    run_stream(7, 0, 0);
    run_stream(2, 4, 2);
    run_stream(0, 3, 1);
    run_stream(1, 1, 0);

    // clr during the 2nd beat; a request offered in that cycle is ignored
    accept(5, 6);
    out_ready = 1'b1;
    check("clr_b1_bit", one_bit, 1);
    tick();
    check("clr_b2_valid", out_valid, 1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_cnt   = DW'(3);
    in_len   = DW'(3);
    tick();
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_last", out_last, 0);
    check("clr_done", done, 0);
    check("clr_ready", in_ready, 1);
    tick();
    check("clr_ignored_valid", out_valid, 0);
    check("clr_no_done", done, 0);
    run_stream(1, 2, 0);

    // Asynchronous reset mid-stream
    accept(200, 255);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_bit", one_bit, 0);
    check("arst_last", out_last, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_rel_ready", in_ready, 1);
    check("arst_no_done", done, 0);
    run_stream(200, 255, 0);

    // Randomized streams
    for (int t = 0; t < 40; t++) begin
      int c, l;
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 14);
      run_stream(c, l, $urandom_range(0, 2));
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
